// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : RV32I memory-access stage. Takes the ALU result as effective
//                address and runs one load/store over a req/ack bus, with
//                lane steering, store strobes, load extension, misalignment
//                detection and a bus timeout. busy stalls the pipeline until
//                done pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int n       = 32,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [2:0]   funct3,
  input  logic [n-1:0] addr,
  input  logic [n-1:0] store_data,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] load_data,
  output logic         fault,
  output logic         bus_req,
  output logic         bus_we,
  output logic [n-1:0] bus_addr,
  output logic [n-1:0] bus_wdata,
  output logic [3:0]   bus_wstrb,
  input  logic         bus_ack,
  input  logic [n-1:0] bus_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     f3_q, f3_d;
  logic [1:0]     alo_q, alo_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [n-1:0]   load_data_q, load_data_d;
  logic           fault_q, fault_d;
  logic           bus_req_q, bus_req_d;
  logic           bus_we_q, bus_we_d;
  logic [n-1:0]   bus_addr_q, bus_addr_d;
  logic [n-1:0]   bus_wdata_q, bus_wdata_d;
  logic [3:0]     bus_wstrb_q, bus_wstrb_d;

  logic           f3_ok, misalign, illegal;
  logic [n-1:0]   st_wdata;
  logic [3:0]     st_wstrb;
  logic [n-1:0]   lane;
  logic [n-1:0]   ld_fmt;

  // Decode legality of the request presented with start
  always_comb begin
    f3_ok = 1'b0;
    if (mem_read && !mem_write) begin
      case (funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_ok = 1'b1;
        default:                                f3_ok = 1'b0;
      endcase
    end else if (mem_write && !mem_read) begin
      case (funct3)
        3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
        default:                f3_ok = 1'b0;
      endcase
    end
    misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
               ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    illegal  = (mem_read && mem_write) ||
               ((mem_read || mem_write) && (!f3_ok || misalign));
  end

  // Store lane replication and byte strobes
  always_comb begin
    st_wdata = store_data;
    st_wstrb = 4'hF;
    case (funct3[1:0])
      2'b00: begin
        st_wdata = {4{store_data[7:0]}};
        st_wstrb = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        st_wdata = {2{store_data[15:0]}};
        st_wstrb = 4'b0011 << {addr[1], 1'b0};
      end
      default: begin
        st_wdata = store_data;
        st_wstrb = 4'hF;
      end
    endcase
  end

  // Shift the addressed lane down and sign/zero extend the load result
  always_comb begin
    lane = bus_rdata >> {alo_q, 3'b000};
    case (f3_q)
      3'b000:  ld_fmt = {{(n-8){lane[7]}}, lane[7:0]};
      3'b001:  ld_fmt = {{(n-16){lane[15]}}, lane[15:0]};
      3'b100:  ld_fmt = {{(n-8){1'b0}}, lane[7:0]};
      3'b101:  ld_fmt = {{(n-16){1'b0}}, lane[15:0]};
      default: ld_fmt = lane;
    endcase
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    f3_d        = f3_q;
    alo_d       = alo_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    load_data_d = load_data_q;
    fault_d     = fault_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_wstrb_d = bus_wstrb_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          f3_d   = funct3;
          alo_d  = addr[1:0];
          busy_d = 1'b1;
          if ((mem_read || mem_write) && !illegal) begin
            state_d     = S_BUS;
            cnt_d       = '0;
            bus_req_d   = 1'b1;
            bus_we_d    = mem_write;
            bus_addr_d  = {addr[n-1:2], 2'b00};
            bus_wdata_d = mem_write ? st_wdata : '0;
            bus_wstrb_d = mem_write ? st_wstrb : 4'b0000;
          end else begin
            // No-op and illegal requests finish without touching the bus
            state_d     = S_FIN;
            done_d      = 1'b1;
            fault_d     = illegal;
            load_data_d = '0;
          end
        end
      end
      S_BUS: begin
        if (bus_ack || (cnt_q == CW'(TIMEOUT - 1))) begin
          // Ack takes priority over a timeout in the same cycle
          state_d     = S_FIN;
          done_d      = 1'b1;
          fault_d     = !bus_ack;
          load_data_d = (bus_ack && !bus_we_q) ? ld_fmt : '0;
          bus_req_d   = 1'b0;
          bus_we_d    = 1'b0;
          bus_addr_d  = '0;
          bus_wdata_d = '0;
          bus_wstrb_d = 4'b0000;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d   = S_IDLE;
        busy_d    = 1'b0;
        bus_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any access immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      f3_q        <= 3'b000;
      alo_q       <= 2'b00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      load_data_q <= '0;
      fault_q     <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_wstrb_q <= 4'b0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      f3_q        <= f3_d;
      alo_q       <= alo_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      load_data_q <= load_data_d;
      fault_q     <= fault_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wstrb_q <= bus_wstrb_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign load_data = load_data_q;
  assign fault     = fault_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_wstrb = bus_wstrb_q;

endmodule
`default_nettype wire
